// File: rtl/mux_pkg.sv
// Shared types and helpers for the round-robin stream mux.
// Mode encoding and modular index increment.
package mux_pkg;

  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } mode_e;

  function automatic int next_idx(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/mux_rr_pipe_rr_pick.sv
// Rotating priority search: first set request at or after the pointer.
// Wraps modulo N, so N need not be a power of two.
module rr_pick #(
  parameter int N  = 8,
  parameter int SW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [SW-1:0] i_ptr,
  output logic          o_gv,
  output logic [SW-1:0] o_gidx
);

  always_comb begin
    int          j;
    logic [SW-1:0] w_k;
    o_gv   = 1'b0;
    o_gidx = '0;
    for (int i = 0; i < N; i++) begin
      j = int'(i_ptr) + i;
      if (j >= N) j = j - N;
      w_k = SW'(j);
      if (!o_gv && i_req[w_k]) begin
        o_gv   = 1'b1;
        o_gidx = w_k;
      end
    end
  end

endmodule

// File: rtl/mux_rr_pipe.sv
// N-channel valid/ready stream mux with fixed or round-robin select
// and a single registered output word.
module mux_rr_pipe
  import mux_pkg::*;
#(
  parameter  int N_CH  = 8,
  parameter  int W     = 8,
  localparam int SEL_W = $clog2(N_CH)
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [N_CH*W-1:0] I_DATA,
  input  logic [N_CH-1:0]   I_VALID,
  output logic [N_CH-1:0]   I_READY,
  input  logic              MODE,
  input  logic [SEL_W-1:0]  S,
  output logic [W-1:0]      OUT_DATA,
  output logic              OUT_VALID,
  output logic [SEL_W-1:0]  OUT_CH,
  input  logic              OUT_READY
);

  logic [W-1:0]     r_data;
  logic             r_valid;
  logic [SEL_W-1:0] r_ch;
  logic [SEL_W-1:0] r_ptr;

  logic             w_rr;
  logic             w_load;
  logic             w_rr_gv;
  logic [SEL_W-1:0] w_rr_gidx;
  logic             w_fx_gv;
  logic             w_gv;
  logic [SEL_W-1:0] w_gidx;
  logic             w_xfer;
  logic [W-1:0]     w_data;

  rr_pick #(
    .N  (N_CH),
    .SW (SEL_W)
  ) u_pick (
    .i_req  (I_VALID),
    .i_ptr  (r_ptr),
    .o_gv   (w_rr_gv),
    .o_gidx (w_rr_gidx)
  );

  assign w_rr    = (MODE == MODE_RR);
  assign w_load  = ~r_valid | OUT_READY;
  // Out-of-range S never grants.
  assign w_fx_gv = (int'(S) < N_CH) && I_VALID[S];

  always_comb begin
    w_gv   = w_fx_gv;
    w_gidx = S;
    if (w_rr) begin
      w_gv   = w_rr_gv;
      w_gidx = w_rr_gidx;
    end
  end

  assign w_xfer = w_load & w_gv;
  assign w_data = I_DATA[int'(w_gidx)*W +: W];

  always_comb begin
    I_READY = '0;
    for (int k = 0; k < N_CH; k++) begin
      I_READY[k] = w_xfer && (w_gidx == SEL_W'(k));
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ch    <= '0;
    end else if (w_load) begin
      r_valid <= w_gv;
      if (w_gv) begin
        r_data <= w_data;
        r_ch   <= w_gidx;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_ptr <= '0;
    end else if (w_xfer && w_rr) begin
      r_ptr <= SEL_W'(next_idx(int'(w_gidx), N_CH));
    end
  end

  assign OUT_DATA  = r_data;
  assign OUT_VALID = r_valid;
  assign OUT_CH    = r_ch;

endmodule
